// File: rtl/pipe_credit_tx.sv
// pipe_credit_tx: credit-based link transmitter.
// Accepts beats from a local valid/ready stream and forwards them on a
// registered, non-backpressured link. A local credit counter mirrors the free
// space in the remote receive buffer, so the link needs no ready wire.
module pipe_credit_tx #(
  parameter int DWIDTH  = 8,
  parameter int CREDITS = 4,
  localparam int CWIDTH = $clog2(CREDITS + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid,
  input  logic              i_credit,
  output logic [CWIDTH-1:0] o_credits,
  output logic              o_idle,
  output logic              o_cred_err
);

  localparam logic [CWIDTH-1:0] CRED_MAX  = CWIDTH'(CREDITS);
  localparam logic [CWIDTH-1:0] CRED_ZERO = {CWIDTH{1'b0}};
  localparam logic [CWIDTH-1:0] CRED_ONE  = CWIDTH'(1);

  logic [CWIDTH-1:0] cnt_r;
  logic [CWIDTH-1:0] cnt_nxt_s;
  logic              valid_r;
  logic [DWIDTH-1:0] data_r;
  logic              err_r;
  logic              err_set_s;
  logic              ready_s;
  logic              send_s;

  // Ready and handshake decoded from the counter register only, so there is
  // no combinational path from i_credit or i_valid to o_ready.
  always_comb begin
    ready_s = (cnt_r != CRED_ZERO);
    send_s  = i_valid & ready_s;
  end

  // Next credit count: a send consumes one credit, a return adds one; both in
  // the same cycle cancel. A return with no send while full is an overflow:
  // the count saturates and the error flag is raised.
  always_comb begin
    cnt_nxt_s = cnt_r;
    err_set_s = 1'b0;
    case ({send_s, i_credit})
      2'b10: begin
        cnt_nxt_s = cnt_r - CRED_ONE;
      end
      2'b01: begin
        if (cnt_r == CRED_MAX) begin
          cnt_nxt_s = CRED_MAX;
          err_set_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + CRED_ONE;
        end
      end
      default: begin
        cnt_nxt_s = cnt_r;
      end
    endcase
  end

  // Credit counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_r <= CRED_MAX;
      err_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      if (err_set_s) begin
        err_r <= 1'b1;
      end
    end
  end

  // Link register: one-cycle strobe per accepted beat, data holds otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_r <= 1'b0;
      data_r  <= {DWIDTH{1'b0}};
    end else begin
      valid_r <= send_s;
      if (send_s) begin
        data_r <= i_data;
      end
    end
  end

  // Output decode from registered state only.
  always_comb begin
    o_ready    = ready_s;
    o_valid    = valid_r;
    o_data     = data_r;
    o_credits  = cnt_r;
    o_cred_err = err_r;
    o_idle     = (cnt_r == CRED_MAX) & ~valid_r;
  end

endmodule

// File: tb/tb_pipe_credit_tx.sv
// Testbench for pipe_credit_tx (DWIDTH=8, CREDITS=4).
// Stimulus pushes the hand-computed beat and the cycle it must appear in onto
// a scoreboard queue; a monitor on the falling edge pops and compares.
module tb_pipe_credit_tx;

  logic       clk;
  logic       rstn;
  logic [7:0] i_data;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_credit;
  logic [2:0] o_credits;
  logic       o_idle;
  logic       o_cred_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;

  exp_t sb_q[$];

  pipe_credit_tx #(.DWIDTH(8), .CREDITS(4)) dut (
    .clk(clk),
    .rstn(rstn),
    .i_data(i_data),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .o_data(o_data),
    .o_valid(o_valid),
    .i_credit(i_credit),
    .o_credits(o_credits),
    .o_idle(o_idle),
    .o_cred_err(o_cred_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle counter used to check link latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Queue the beat being driven now; it must show on the link next cycle.
  task automatic expect_beat(input logic [7:0] d);
    exp_t e;
    e.d = d;
    e.c = cyc + 1;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every link beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rstn && o_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_beat", {24'h0, o_data}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("beat_data", {24'h0, o_data}, {24'h0, e.d});
        check("beat_cycle", cyc, e.c);
      end
    end
  end

  initial begin
    rstn     = 1'b1;
    i_data   = 8'h00;
    i_valid  = 1'b0;
    i_credit = 1'b0;

    // Asynchronous reset, checked before any clock edge.
    #1 rstn = 1'b0;
    #1;
    check("rst_valid", o_valid, 1'b0);
    check("rst_data", o_data, 8'h00);
    check("rst_ready", o_ready, 1'b1);
    check("rst_credits", o_credits, 3'd4);
    check("rst_idle", o_idle, 1'b1);
    check("rst_err", o_cred_err, 1'b0);
    #10 rstn = 1'b1;

    // Exhaustion: 4 beats accepted, 0x55 held off.
    tick();
    i_valid = 1'b1;
    i_data = 8'h11; expect_beat(8'h11); tick();
    check("exh_cred3", o_credits, 3'd3);
    i_data = 8'h22; expect_beat(8'h22); tick();
    check("exh_cred2", o_credits, 3'd2);
    i_data = 8'h33; expect_beat(8'h33); tick();
    check("exh_cred1", o_credits, 3'd1);
    check("exh_ready1", o_ready, 1'b1);
    i_data = 8'h44; expect_beat(8'h44); tick();
    check("exh_cred0", o_credits, 3'd0);
    check("exh_ready0", o_ready, 1'b0);
    i_data = 8'h55; tick();
    check("exh_hold_ready", o_ready, 1'b0);
    check("exh_hold_credits", o_credits, 3'd0);
    check("exh_hold_valid", o_valid, 1'b0);

    // Resume: one credit lets 0x55 through.
    i_credit = 1'b1; tick();
    i_credit = 1'b0;
    check("res_ready", o_ready, 1'b1);
    check("res_cred1", o_credits, 3'd1);
    expect_beat(8'h55); tick();
    i_valid = 1'b0;
    check("res_cred0", o_credits, 3'd0);
    check("res_ready0", o_ready, 1'b0);

    // Simultaneous send and credit at cnt=1.
    i_credit = 1'b1; tick();
    check("sim_start_cred", o_credits, 3'd1);
    i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      i_data = 8'hA0 + 8'(k);
      expect_beat(i_data);
      tick();
      check("sim_cred", o_credits, 3'd1);
      check("sim_ready", o_ready, 1'b1);
    end
    i_valid = 1'b0;
    i_credit = 1'b0;
    tick();
    check("sim_end_cred", o_credits, 3'd1);

    // Refill to full.
    i_credit = 1'b1;
    tick(); tick(); tick();
    i_credit = 1'b0;
    check("refill_cred", o_credits, 3'd4);
    check("refill_idle", o_idle, 1'b1);
    check("refill_err", o_cred_err, 1'b0);

    // Overflow: extra credit while full.
    i_credit = 1'b1; tick();
    i_credit = 1'b0;
    check("ovf_cred", o_credits, 3'd4);
    check("ovf_err", o_cred_err, 1'b1);
    i_valid = 1'b1; i_data = 8'h66; expect_beat(8'h66); tick();
    i_valid = 1'b0;
    check("ovf_traffic_cred", o_credits, 3'd3);
    check("ovf_traffic_idle", o_idle, 1'b0);
    check("ovf_sticky1", o_cred_err, 1'b1);
    i_credit = 1'b1; tick();
    i_credit = 1'b0;
    check("ovf_back_cred", o_credits, 3'd4);
    check("ovf_back_idle", o_idle, 1'b1);
    check("ovf_sticky2", o_cred_err, 1'b1);

    // Reset mid-burst after two beats.
    i_valid = 1'b1;
    i_data = 8'hC1; expect_beat(8'hC1); tick();
    i_data = 8'hC2; expect_beat(8'hC2); tick();
    check("mid_valid_before", o_valid, 1'b1);
    check("mid_cred_before", o_credits, 3'd2);
    #1;
    rstn = 1'b0;
    i_valid = 1'b0;
    sb_q.delete();  // beat in flight is dropped by reset
    #1;
    check("mid_rst_valid", o_valid, 1'b0);
    check("mid_rst_cred", o_credits, 3'd4);
    check("mid_rst_idle", o_idle, 1'b1);
    check("mid_rst_err", o_cred_err, 1'b0);
    @(negedge clk);
    #2 rstn = 1'b1;
    tick();
    i_valid = 1'b1; i_data = 8'hD1; expect_beat(8'hD1); tick();
    i_valid = 1'b0;
    check("post_rst_cred", o_credits, 3'd3);
    check("post_rst_valid", o_valid, 1'b1);
    tick();
    check("post_rst_valid_low", o_valid, 1'b0);
    tick(); tick();

    check("sb_empty", sb_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_credit_tx.md
# pipe_credit_tx

Credit-based link transmitter that sits at the upstream end of a valid/ready pipeline stage. It terminates a local valid/ready stream and drives a registered, non-backpressured link (`o_valid`/`o_data`) toward a remote receiver with a CREDITS-deep input buffer. The remote receiver signals each freed entry with a one-cycle `i_credit` pulse. Flow control is enforced entirely by an internal credit counter, so the link never needs a ready wire.

## Interface
- `DWIDTH`, 8: data width in bits.
- `CREDITS`, 4: initial and maximum credit count, equal to the remote buffer depth; legal range 1..255.
- `CWIDTH`, derived as $clog2(CREDITS+1): credit counter width; not overridable.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `i_data`  in  DWIDTH  upstream data.
- `i_valid`  in  1  upstream data valid.
- `o_ready`  out  1  upstream ready; high when the credit counter is nonzero.
- `o_data`  out  DWIDTH  link data; registered.
- `o_valid`  out  1  link beat strobe; registered, high for one cycle per beat.
- `i_credit`  in  1  credit return pulse; one credit per high cycle.
- `o_credits`  out  CWIDTH  current credit count.
- `o_idle`  out  1  high when `o_credits == CREDITS` and `o_valid == 0`, i.e. nothing is in flight.
- `o_cred_err`  out  1  sticky credit-overflow flag.

## Operation
- **Credit counter `cnt`.**
  - Reset value is CREDITS.
  - `send = i_valid && o_ready`.
  - Next value: `cnt_nxt = cnt - send + i_credit`.
- **Driving `o_ready`.**
  - `o_ready = (cnt != 0)`.
  - It is decoded from the register only; there is no combinational path from `i_credit` or `i_valid`.
- **Sending a beat.**
  - On `send`: `o_data <= i_data` and `o_valid <= 1`.
  - Otherwise `o_valid <= 0`, and `o_data` holds its last value.
- **Simultaneous send and credit return.** `send` and `i_credit` in the same cycle leave `cnt` unchanged, including when `cnt == 1`.
- **Credit overflow.**
  - Condition: `i_credit` with no send while `cnt == CREDITS`.
  - Response: `cnt` saturates at CREDITS and `o_cred_err <= 1`.
  - `o_cred_err` clears only on reset.
- **`i_credit` while `cnt == 0`.** This is legal: `cnt` becomes 1, and `o_ready` rises the next cycle.
- **Upstream rules.**
  - `i_valid` without `o_ready` is not an error; data is simply not taken.
  - Upstream may drop `i_valid` at any time.
- **Reset values.** Every output takes its reset value asynchronously as soon as `rstn` falls:
  - `o_valid` = 0
  - `o_data` = 0
  - `o_ready` = 1
  - `o_credits` = CREDITS
  - `o_idle` = 1
  - `o_cred_err` = 0
- **Reset mid-operation.**
  - A beat in flight on `o_valid` is dropped.
  - Outstanding credits are forgotten, and the counter reloads to CREDITS.
  - The remote receiver must be reset in the same domain.

## Timing
- **Accept-to-link latency.** A beat accepted in cycle t appears on `o_valid`/`o_data` in cycle t+1. Throughput is 1 beat/cycle while credits last.
- **Credit return.** `i_credit` in cycle t is reflected in `o_credits` and `o_ready` in cycle t+1.
- **Exhaustion.** Starting from CREDITS with `i_valid` held high and no returns:
  - exactly CREDITS beats are accepted on consecutive cycles;
  - `o_ready` falls in the cycle after the last accept.
- **Sustained rate.** Full rate requires a credit round trip of at most CREDITS cycles.
- **`o_idle`.** Registered-equivalent: derived only from `cnt` and `o_valid`.

## Test plan
- **Reset.** Assert `rstn=0` mid-cycle.
  - Required response: outputs go to `o_valid=0`, `o_ready=1`, `o_credits=4`, `o_idle=1`, `o_cred_err=0` without waiting for a clock edge.
- **Exhaustion (CREDITS=4).** Hold `i_valid=1` with data 0x11, 0x22, 0x33, 0x44, 0x55 and no credits.
  - Required response: `o_valid` pulses on 4 consecutive cycles carrying 0x11..0x44.
  - `o_ready=0` from the cycle after 0x44 is accepted; `o_credits=0`; 0x55 is held off.
- **Resume after exhaustion.** From `cnt=0`, pulse `i_credit` for one cycle while 0x55 is pending.
  - Required response: `o_ready=1` the next cycle; 0x55 is accepted; `o_valid` shows 0x55 one cycle later; `o_credits` returns to 0.
- **Simultaneous send and credit.** At `cnt=1`, assert `send` and `i_credit` in the same cycle for 3 consecutive cycles.
  - Required response: `o_credits` stays 1 throughout; 3 beats emitted back-to-back; `o_ready` never drops.
- **Credit overflow.** At `cnt=4`, idle, pulse `i_credit`.
  - Required response: `o_credits` stays 4; `o_cred_err=1` and remains 1 through later normal traffic until reset.
- **Reset mid-burst.** After 2 of 4 beats are sent, assert and release `rstn`.
  - Required response: `o_credits=4`, `o_valid=0`, `o_idle=1`.
  - The next accept emits on `o_valid` one cycle later.
